// File: rtl/csr_timer_array_pkg.sv
// Shared register map for csr_timer_array (the csr_timer_defs set): register offsets,
// CFG field positions, channel FSM encodings and the PSC address.
package csr_timer_array_pkg;

  localparam logic [1:0] REG_CFG  = 2'd0;
  localparam logic [1:0] REG_VAL  = 2'd1;
  localparam logic [1:0] REG_CLR  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CFG_EN_BIT    = 0;
  localparam int CFG_PER_BIT   = 1;
  localparam int CFG_IE_BIT    = 2;
  localparam int CFG_INITV_LSB = 4;

  localparam logic [4:0] PSC_ADDR = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  // Bit-masked register update: only bits with mask=1 take the new value.
  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [31:0] mask);
    return (new_v & mask) | (old_v & ~mask);
  endfunction

endpackage

// File: rtl/csr_timer_array_if.sv
// CSR access port of csr_timer_array.
// csr_we is a single-cycle strobe: the write lands on the rising edge where it is
// sampled high; csr_rdata is combinational from csr_addr with no wait states.
interface csr_timer_array_if;
  logic [4:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic        csr_we;
  logic [31:0] csr_rdata;

  modport master (output csr_addr, csr_wdata, csr_wmask, csr_we, input csr_rdata);
  modport slave  (input csr_addr, csr_wdata, csr_wmask, csr_we, output csr_rdata);
endinterface

// File: rtl/csr_timer_array_timer_channel.sv
// One down-counting timer channel: CFG register, VAL counter, pending flag and the
// IDLE/RUN/DONE FSM.
module timer_channel
  import csr_timer_array_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [31:0]      cfg_wdata,
  input  logic [31:0]      cfg_wmask,
  input  logic             clr,
  output logic [31:0]      cfg_rd,
  output logic [CNT_W-1:0] val,
  output logic             pending,
  output logic             running,
  output logic             ie,
  output ch_state_e        state
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] val_q, val_d, initv_q, initv_d;
  logic             en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;
  logic [31:0]      cfg_new;
  logic             expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      initv_q <= '0;
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      initv_q <= initv_d;
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    cfg_rd = '0;
    cfg_rd[CFG_EN_BIT]                     = en_q;
    cfg_rd[CFG_PER_BIT]                    = per_q;
    cfg_rd[CFG_IE_BIT]                     = ie_q;
    cfg_rd[CNT_W+CFG_INITV_LSB-1:CFG_INITV_LSB] = initv_q;
    cfg_new = wmerge(cfg_rd, cfg_wdata, cfg_wmask);
  end

  // A CFG write on the expiry edge takes priority and suppresses the expiry.
  assign expire = tick && (state_q == ST_RUN) && (val_q == '0) && !cfg_we;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    initv_d = initv_q;
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    if (cfg_we) begin
      en_d    = cfg_new[CFG_EN_BIT];
      per_d   = cfg_new[CFG_PER_BIT];
      ie_d    = cfg_new[CFG_IE_BIT];
      initv_d = cfg_new[CNT_W+CFG_INITV_LSB-1:CFG_INITV_LSB];
      if (cfg_new[CFG_EN_BIT]) begin
        state_d = ST_RUN;
        val_d   = cfg_new[CNT_W+CFG_INITV_LSB-1:CFG_INITV_LSB];
      end else begin
        state_d = ST_IDLE;
      end
    end else if (tick && state_q == ST_RUN) begin
      if (val_q != '0) val_d = val_q - 1'b1;
      else if (per_q)  val_d = initv_q;
      else             state_d = ST_DONE;
    end
    // Expiry beats a same-edge clear.
    if (expire)   pend_d = 1'b1;
    else if (clr) pend_d = 1'b0;
  end

  assign val     = val_q;
  assign pending = pend_q;
  assign running = (state_q == ST_RUN);
  assign ie      = ie_q;
  assign state   = state_q;

endmodule

// File: rtl/csr_timer_array.sv
// Array of NUM_CH CSR-programmable down-count timers with a free-running 64-bit counter.
// Optional global tick prescaler compiled in with TIMER_PRESCALE_EN.
module csr_timer_array
  import csr_timer_array_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  csr_timer_array_if.slave      csr,
  output logic [NUM_CH-1:0]     irq_pending,
  output logic                  interrupt,
  output logic [63:0]           stable_counter,
  output logic [2*NUM_CH-1:0]   ch_state_dbg
);

  logic [2:0]       ch_idx;
  logic [1:0]       reg_sel;
  logic             tick;
  logic [31:0]      cfg_rd [NUM_CH];
  logic [CNT_W-1:0] val    [NUM_CH];
  logic [NUM_CH-1:0] running, ie_vec;
  logic [63:0]      stable_q;

  assign ch_idx  = csr.csr_addr[4:2];
  assign reg_sel = csr.csr_addr[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e st;
    logic      hit;
    assign hit = csr.csr_we && (ch_idx == 3'(g));
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .cfg_we    (hit && reg_sel == REG_CFG),
      .cfg_wdata (csr.csr_wdata),
      .cfg_wmask (csr.csr_wmask),
      .clr       (hit && reg_sel == REG_CLR && csr.csr_wdata[0] && csr.csr_wmask[0]),
      .cfg_rd    (cfg_rd[g]),
      .val       (val[g]),
      .pending   (irq_pending[g]),
      .running   (running[g]),
      .ie        (ie_vec[g]),
      .state     (st)
    );
    assign ch_state_dbg[2*g +: 2] = st;
  end

  assign interrupt = |(irq_pending & ie_vec);

`ifdef TIMER_PRESCALE_EN
  logic [7:0]  psc_q, pcnt_q;
  logic [31:0] psc_new;
  logic        psc_we;

  assign psc_we  = csr.csr_we && (csr.csr_addr == PSC_ADDR);
  assign psc_new = wmerge({24'b0, psc_q}, csr.csr_wdata, csr.csr_wmask);
  assign tick    = (pcnt_q == psc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q  <= '0;
      pcnt_q <= '0;
    end else if (psc_we) begin
      psc_q  <= psc_new[7:0];
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    csr.csr_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 3'(i)) begin
        case (reg_sel)
          REG_CFG:  csr.csr_rdata = cfg_rd[i];
          REG_VAL:  csr.csr_rdata = 32'(val[i]);
          REG_STAT: csr.csr_rdata = {30'b0, running[i], irq_pending[i]};
          default:  csr.csr_rdata = '0;
        endcase
      end
    end
`ifdef TIMER_PRESCALE_EN
    if (csr.csr_addr == PSC_ADDR) csr.csr_rdata = {24'b0, psc_q};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= '0;
    else     stable_q <= stable_q + 64'd1;
  end

  assign stable_counter = stable_q;

endmodule

// File: tb/tb_csr_timer_array.sv
// Self-checking bench for csr_timer_array: table-driven one-shot sequence plus
// hand-written periodic, collision, masking, prescaler and reset sequences.
module tb_csr_timer_array;
  import csr_timer_array_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic               clk;
  logic               rst;
  logic [NUM_CH-1:0]  irq_pending;
  logic               interrupt;
  logic [63:0]        stable_counter;
  logic [2*NUM_CH-1:0] ch_state_dbg;

  csr_timer_array_if csr_bus ();

  csr_timer_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr            (csr_bus.slave),
    .irq_pending    (irq_pending),
    .interrupt      (interrupt),
    .stable_counter (stable_counter),
    .ch_state_dbg   (ch_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    int          pre;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] mask);
    csr_bus.csr_addr  = addr;
    csr_bus.csr_wdata = data;
    csr_bus.csr_wmask = mask;
    csr_bus.csr_we    = 1'b1;
    @(posedge clk);
    #1;
    csr_bus.csr_we    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    csr_bus.csr_addr = addr;
    #2;
    e = exp_q.pop_front();
    chk(name, csr_bus.csr_rdata, e);
  endtask

  logic [63:0] s0;

  initial begin
    csr_bus.csr_addr  = '0;
    csr_bus.csr_wdata = '0;
    csr_bus.csr_wmask = '0;
    csr_bus.csr_we    = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_stable", stable_counter, 64'd0);
    chk("rst_irq", irq_pending, 4'b0);
    chk("rst_int", interrupt, 1'b0);
    rd("rst_cfg0", 5'd0, 32'h0);
    step(2);
    rst = 1'b0;

    // One-shot on ch0, INITV=5 EN IE; plus write to nonexistent channel 5.
    tbl[0]  = '{1'b1, 5'd0,  32'h55, 32'hFFFF_FFFF, 0, 32'h0};
    tbl[1]  = '{1'b0, 5'd1,  32'h0,  32'h0, 0, 32'd5};
    tbl[2]  = '{1'b0, 5'd1,  32'h0,  32'h0, 1, 32'd4};
    tbl[3]  = '{1'b0, 5'd1,  32'h0,  32'h0, 1, 32'd3};
    tbl[4]  = '{1'b0, 5'd1,  32'h0,  32'h0, 1, 32'd2};
    tbl[5]  = '{1'b0, 5'd1,  32'h0,  32'h0, 1, 32'd1};
    tbl[6]  = '{1'b0, 5'd1,  32'h0,  32'h0, 1, 32'd0};
    tbl[7]  = '{1'b0, 5'd3,  32'h0,  32'h0, 0, 32'h2};
    tbl[8]  = '{1'b0, 5'd3,  32'h0,  32'h0, 1, 32'h1};
    tbl[9]  = '{1'b0, 5'd1,  32'h0,  32'h0, 1, 32'd0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,  32'h0, 0, 32'h55};
    tbl[11] = '{1'b1, 5'd20, 32'h55, 32'hFFFF_FFFF, 0, 32'h0};
    tbl[12] = '{1'b0, 5'd20, 32'h0,  32'h0, 0, 32'h0};

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
      else begin
        step(tbl[i].pre);
        rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
      end
    end
    chk("os_int", interrupt, 1'b1);
    chk("os_irq", irq_pending, 4'b0001);
    chk("os_state", ch_state_dbg[1:0], ST_DONE);
    wr(5'd2, 32'h1, 32'h1);
    chk("clr0_irq", irq_pending, 4'b0000);
    chk("clr0_int", interrupt, 1'b0);

    // Periodic ch1: INITV=3 PERIODIC EN IE.
    wr(5'd4, 32'h37, 32'hFFFF_FFFF);
    rd("per_v3", 5'd5, 32'd3);
    step(3);
    rd("per_v0", 5'd5, 32'd0);
    rd("per_st_run", 5'd7, 32'h2);
    step(1);
    rd("per_st_pend", 5'd7, 32'h3);
    rd("per_reload", 5'd5, 32'd3);
    chk("per_irq", irq_pending, 4'b0010);
    wr(5'd6, 32'h1, 32'h1);
    rd("per_clr_st", 5'd7, 32'h2);
    step(2);
    rd("per_v0b", 5'd5, 32'd0);
    rd("per_nopend", 5'd7, 32'h2);
    wr(5'd6, 32'h1, 32'h1);                // CLR on expiry edge
    rd("coll_clr_st", 5'd7, 32'h3);
    rd("coll_clr_v", 5'd5, 32'd3);
    wr(5'd6, 32'h1, 32'h1);
    step(2);
    wr(5'd4, 32'h37, 32'hFFFF_FFFF);       // CFG rewrite on expiry edge
    rd("coll_cfg_v", 5'd5, 32'd3);
    rd("coll_cfg_st", 5'd7, 32'h2);
    wr(5'd4, 32'h0, 32'hFFFF_FFFF);
    step(3);
    rd("dis_hold_v", 5'd5, 32'd3);
    rd("dis_st", 5'd7, 32'h0);

    // Masking ch2: INITV=1 EN, IE=0.
    wr(5'd8, 32'h11, 32'hFFFF_FFFF);
    step(2);
    chk("mask_irq", irq_pending, 4'b0100);
    chk("mask_int0", interrupt, 1'b0);
    wr(5'd8, 32'h4, 32'h4);
    chk("mask_int1", interrupt, 1'b1);
    rd("mask_cfg", 5'd8, 32'h15);
    rd("mask_val", 5'd9, 32'd1);
    wr(5'd8, 32'h0, 32'hFFFF_FFFF);
    wr(5'd10, 32'h1, 32'h1);
    chk("mask_clr_irq", irq_pending, 4'b0000);

    // Prescaler on ch3, INITV=2 EN.
`ifdef TIMER_PRESCALE_EN
    wr(5'd28, 32'h2, 32'hFF);
    rd("psc_rd", 5'd28, 32'h2);
    wr(5'd12, 32'h21, 32'hFFFF_FFFF);
    rd("psc_v2a", 5'd13, 32'd2);
    step(1);
    rd("psc_v2b", 5'd13, 32'd2);
    step(1);
    rd("psc_v1a", 5'd13, 32'd1);
    step(2);
    rd("psc_v1b", 5'd13, 32'd1);
    step(1);
    rd("psc_v0", 5'd13, 32'd0);
`else
    wr(5'd28, 32'h2, 32'hFF);
    rd("psc_rd0", 5'd28, 32'h0);
    wr(5'd12, 32'h21, 32'hFFFF_FFFF);
    rd("nopsc_v2", 5'd13, 32'd2);
    step(1);
    rd("nopsc_v1", 5'd13, 32'd1);
    step(1);
    rd("nopsc_v0", 5'd13, 32'd0);
`endif

    s0 = stable_counter;
    step(7);
    chk("stable_inc", stable_counter, s0 + 64'd7);

    // Reset mid-count on ch0: INITV=10.
    wr(5'd0, 32'hA5, 32'hFFFF_FFFF);
    step(6);
    rd("rm_v4", 5'd1, 32'd4);
    rst = 1'b1;
    #1;
    chk("rm_irq", irq_pending, 4'b0);
    chk("rm_int", interrupt, 1'b0);
    chk("rm_stable", stable_counter, 64'd0);
    rd("rm_val", 5'd1, 32'd0);
    rd("rm_cfg", 5'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rm_stable_rel", stable_counter, 64'd0);
    step(12);
    chk("rm_nopend", irq_pending, 4'b0);
    rd("rm_val_after", 5'd1, 32'd0);
    chk("rm_state", ch_state_dbg, 8'h00);
    chk("rm_stable12", stable_counter, 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_timer_array.md
CSR_TIMER_ARRAY -- requirements
Module: csr_timer_array

Interface
REQ-001 Parameter NUM_CH, default 4, number of timer channels, legal range 1..7.
REQ-002 Parameter CNT_W, default 16, counter width per channel, legal range 4..28.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 csr_addr  input  5  [4:2] channel index, [1:0] register select (0 CFG, 1 VAL, 2 CLR, 3 STAT).
REQ-006 csr_wdata  input  32  write data.
REQ-007 csr_wmask  input  32  per-bit write mask; new = (wdata & wmask) | (old & ~wmask).
REQ-008 csr_we  input  1  write strobe, single-cycle.
REQ-009 csr_rdata  output  32  combinational read data for csr_addr.
REQ-010 irq_pending  output  NUM_CH  per-channel pending bits.
REQ-011 interrupt  output  1  OR over channels of (pending & CFG.IE).
REQ-012 stable_counter  output  64  free-running cycle counter.

Function
REQ-013 CFG fields: [0] EN, [1] PERIODIC, [2] IE, [CNT_W+3:4] INITV; other bits read 0 and ignore writes.
REQ-014 VAL is read-only, zero-extended current count; writes ignored.
REQ-015 CLR is write-only, reads 0; write with wdata[0]&wmask[0] clears that channel's pending.
REQ-016 STAT reads {30'b0, running, pending}.
REQ-017 Each channel FSM has states IDLE, RUN, DONE; reset state IDLE.
REQ-018 Any CFG write leaving EN=1 moves the channel to RUN and loads VAL=INITV (new value) on the same edge.
REQ-019 CFG write leaving EN=0 moves the channel to IDLE; VAL holds its value.
REQ-020 In RUN on a tick with VAL!=0, VAL decrements by 1.
REQ-021 In RUN on a tick with VAL==0: pending set; if PERIODIC, VAL reloads INITV and stays RUN; else goes to DONE with VAL held at 0.
REQ-022 DONE exits only via CFG write (REQ-018/019).
REQ-023 INITV=0 with PERIODIC=1 sets pending on every tick.
REQ-024 Expiry and CLR on the same edge: set wins, pending=1.
REQ-025 CFG write and expiry on the same edge: CFG write wins, no pending set that edge.
REQ-026 Accesses to channel index >= NUM_CH (except REQ-033) read 0 and ignore writes.
REQ-027 stable_counter increments by 1 every cycle, wraps at 2^64-1 to 0.
REQ-028 irq_pending and interrupt are combinational from registered state; zero added latency.

Reset
REQ-029 rst asserted: all channels IDLE, CFG=0, VAL=0, pending=0, stable_counter=0, interrupt=0, csr_rdata reflects zeros.
REQ-030 rst asserted mid-count abandons the count immediately; no pending generated on release.

Configuration
REQ-031 Macro TIMER_PRESCALE_EN compiles in a global prescaler.
REQ-032 Without TIMER_PRESCALE_EN every clock cycle is a tick.
REQ-033 With it, register PSC (8 bits) at csr_addr 5'b11100; a tick occurs when the prescale counter equals PSC, counter then returns to 0; PSC=0 means every cycle; PSC write resets the prescale counter; reset value PSC=0.
REQ-034 Without the macro, address 5'b11100 reads 0, writes ignored.

Structure
REQ-035 Shared defines header csr_timer_defs holds register offsets, CFG field positions, FSM state encodings, PSC address.
REQ-036 One sub-module timer_channel (FSM, VAL, pending) instantiated NUM_CH times via generate; top holds decode, read mux, prescaler, stable_counter.

Verification
REQ-037 One-shot: CFG=0x0000_0055 (INITV=5, EN, IE) -> VAL 5,4,..,0; pending and interrupt rise on the edge after VAL=0 observed; STAT=0x1; VAL stays 0.
REQ-038 Periodic: INITV=3, PERIODIC=1 -> pending set every 4 cycles, VAL sequence 3,2,1,0,3; CLR mid-period clears pending until next expiry.
REQ-039 Collision: CLR write on expiry edge -> pending stays 1; CFG rewrite on expiry edge -> VAL=INITV, pending unchanged.
REQ-040 Masking: IE=0, expiry -> irq_pending[ch]=1, interrupt=0; wmask=0x4 write of IE=1 -> interrupt=1 without VAL reload side effects beyond REQ-018.
REQ-041 Prescaler (macro on): PSC=2, INITV=2 -> VAL decrements every 3 cycles; macro off -> every cycle, PSC reads 0.
REQ-042 Reset mid-count: INITV=10 running, rst pulse at VAL=4 -> all outputs 0, stable_counter restarts at 0.
